// File: rtl/traffic_phase_sequencer_pkg.sv
// Shared types for the traffic phase sequencer: lamp codes, phase encoding,
// per-head lamp bundle and the phase-to-lamp decode.
package tl_pkg;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  typedef enum logic [3:0] {
    MAIN_GREEN = 4'd0,
    M2_YEL     = 4'd1,
    TURN_GREEN = 4'd2,
    TURN_YEL   = 4'd3,
    CLR_A      = 4'd4,
    SIDE_GREEN = 4'd5,
    SIDE_YEL   = 4'd6,
    CLR_B      = 4'd7,
    FLASH      = 4'd8
  } phase_t;

  typedef struct packed {
    logic [2:0] m1;
    logic [2:0] m2;
    logic [2:0] mt;
    logic [2:0] s;
  } lamp_set_t;

  // Unlisted encodings fall through to all-red so a corrupted state is safe.
  function automatic lamp_set_t decode_lamps(input phase_t ph, input logic blink);
    lamp_set_t l;
    l = '{m1: LAMP_RED, m2: LAMP_RED, mt: LAMP_RED, s: LAMP_RED};
    case (ph)
      MAIN_GREEN: begin l.m1 = LAMP_GRN; l.m2 = LAMP_GRN; end
      M2_YEL:     begin l.m1 = LAMP_GRN; l.m2 = LAMP_YEL; end
      TURN_GREEN: begin l.m1 = LAMP_GRN; l.mt = LAMP_GRN; end
      TURN_YEL:   begin l.m1 = LAMP_YEL; l.mt = LAMP_YEL; end
      SIDE_GREEN: l.s = LAMP_GRN;
      SIDE_YEL:   l.s = LAMP_YEL;
      FLASH: begin
        l.m1 = blink ? LAMP_YEL : LAMP_OFF;
        l.m2 = blink ? LAMP_YEL : LAMP_OFF;
        l.mt = blink ? LAMP_YEL : LAMP_OFF;
        l.s  = blink ? LAMP_RED : LAMP_OFF;
      end
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_sequencer_timer.sv
// Phase tick counter: advances on tick strobes, restarts on any phase change,
// and flags the tick that completes the selected duration.
module tl_phase_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_i,
  input  logic             restart_i,
  input  logic [CNT_W-1:0] dur_i,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign done_o = tick_i && (count_q == (dur_i - 1'b1));

  // Next count: clear on phase change, otherwise count ticks.
  always_comb begin
    count_d = count_q;
    if (restart_i) begin
      count_d = '0;
    end else if (tick_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Four-head junction phase sequencer with clearance phases, demand-actuated
// side phase and night flash mode. Durations are counted in tick strobes.
module traffic_phase_sequencer
  import tl_pkg::*;
#(
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned T_MAIN       = 8,
  parameter int unsigned T_YEL        = 3,
  parameter int unsigned T_TURN       = 6,
  parameter int unsigned T_CLR        = 1,
  parameter int unsigned T_SIDE       = 4,
  parameter bit          SIDE_SKIP_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       side_req,
  input  logic       flash_mode,
  output logic [2:0] M1,
  output logic [2:0] M2,
  output logic [2:0] MT,
  output logic [2:0] S,
  output logic [3:0] phase,
  output logic       cycle_start
);

  // A zero duration would never complete; it is run as a one-tick phase.
  localparam logic [CNT_W-1:0] D_MAIN = CNT_W'((T_MAIN == 0) ? 1 : T_MAIN);
  localparam logic [CNT_W-1:0] D_YEL  = CNT_W'((T_YEL  == 0) ? 1 : T_YEL);
  localparam logic [CNT_W-1:0] D_TURN = CNT_W'((T_TURN == 0) ? 1 : T_TURN);
  localparam logic [CNT_W-1:0] D_CLR  = CNT_W'((T_CLR  == 0) ? 1 : T_CLR);
  localparam logic [CNT_W-1:0] D_SIDE = CNT_W'((T_SIDE == 0) ? 1 : T_SIDE);

  if (T_MAIN == 0 || T_YEL == 0 || T_TURN == 0 || T_CLR == 0 || T_SIDE == 0) begin : g_zero_dur
    $warning("traffic_phase_sequencer: zero phase duration runs as 1 tick");
  end

  phase_t           state_q, state_d;
  logic             req_q, req_d;
  logic             blink_q, blink_d;
  logic             cycle_start_q, cycle_start_d;
  logic [CNT_W-1:0] dur_sel;
  logic             done;
  logic             restart;
  lamp_set_t        lamps;

  tl_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .tick_i   (tick),
    .restart_i(restart),
    .dur_i    (dur_sel),
    .done_o   (done)
  );

  // Duration selection and phase sequencing.
  always_comb begin
    state_d = state_q;
    dur_sel = D_CLR;
    case (state_q)
      MAIN_GREEN: begin
        dur_sel = D_MAIN;
        if (done) state_d = M2_YEL;
      end
      M2_YEL: begin
        dur_sel = D_YEL;
        if (done) state_d = TURN_GREEN;
      end
      TURN_GREEN: begin
        dur_sel = D_TURN;
        if (done) state_d = TURN_YEL;
      end
      TURN_YEL: begin
        dur_sel = D_YEL;
        if (done) state_d = CLR_A;
      end
      CLR_A: begin
        dur_sel = D_CLR;
        if (done) begin
          if (flash_mode)                   state_d = FLASH;
          else if (req_q || !SIDE_SKIP_EN)  state_d = SIDE_GREEN;
          else                              state_d = MAIN_GREEN;
        end
      end
      SIDE_GREEN: begin
        dur_sel = D_SIDE;
        if (done) state_d = SIDE_YEL;
      end
      SIDE_YEL: begin
        dur_sel = D_YEL;
        if (done) state_d = CLR_B;
      end
      CLR_B: begin
        dur_sel = D_CLR;
        if (done) state_d = flash_mode ? FLASH : MAIN_GREEN;
      end
      FLASH: begin
        if (tick && !flash_mode) state_d = CLR_B;
      end
      default: state_d = CLR_B;
    endcase
  end

  // Request latch, blink and cycle-start pulse derived from the transition.
  always_comb begin
    restart = (state_d != state_q);
    req_d   = req_q;
    if (state_d == SIDE_GREEN && state_q != SIDE_GREEN) begin
      req_d = 1'b0;
    end else if (side_req) begin
      req_d = 1'b1;
    end
    blink_d = 1'b0;
    if (state_d == FLASH) begin
      blink_d = (state_q == FLASH && tick) ? ~blink_q : blink_q;
    end
    cycle_start_d = (state_d == MAIN_GREEN) && (state_q != MAIN_GREEN);
  end

  // State and auxiliary registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= MAIN_GREEN;
      req_q         <= 1'b0;
      blink_q       <= 1'b0;
      cycle_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      blink_q       <= blink_d;
      cycle_start_q <= cycle_start_d;
    end
  end

  // Lamp decode straight from registered state.
  always_comb begin
    lamps       = decode_lamps(state_q, blink_q);
    M1          = lamps.m1;
    M2          = lamps.m2;
    MT          = lamps.mt;
    S           = lamps.s;
    phase       = state_q;
    cycle_start = cycle_start_q;
  end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed, table-driven bench for traffic_phase_sequencer.
module tb_traffic_phase_sequencer;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] O = 3'b000;

  localparam logic [3:0] P_MAIN = 4'd0;
  localparam logic [3:0] P_M2Y  = 4'd1;
  localparam logic [3:0] P_TURN = 4'd2;
  localparam logic [3:0] P_TY   = 4'd3;
  localparam logic [3:0] P_CLRA = 4'd4;
  localparam logic [3:0] P_SG   = 4'd5;
  localparam logic [3:0] P_SY   = 4'd6;
  localparam logic [3:0] P_CLRB = 4'd7;
  localparam logic [3:0] P_FL   = 4'd8;

  typedef struct {
    int unsigned n;
    int unsigned per;
    logic        sreq;
    logic        fl;
    logic [3:0]  ph;
    logic [2:0]  m1, m2, mt, s;
    logic        cs;
  } seg_t;

  logic       clk = 1'b0;
  logic       reset, tick, side_req, flash_mode;
  logic [2:0] M1, M2, MT, S;
  logic [3:0] phase;
  logic       cycle_start;

  int unsigned checks = 0;
  int unsigned errors = 0;
  seg_t        segs[$];

  always #5 clk = ~clk;

  traffic_phase_sequencer #(
    .CNT_W(4), .T_MAIN(8), .T_YEL(3), .T_TURN(6), .T_CLR(1), .T_SIDE(4),
    .SIDE_SKIP_EN(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .side_req(side_req),
    .flash_mode(flash_mode), .M1(M1), .M2(M2), .MT(MT), .S(S),
    .phase(phase), .cycle_start(cycle_start)
  );

  function automatic void add(int unsigned n, int unsigned per, logic sreq, logic fl,
                              logic [3:0] ph, logic [2:0] m1, logic [2:0] m2,
                              logic [2:0] mt, logic [2:0] s, logic cs);
    seg_t t;
    t.n = n; t.per = per; t.sreq = sreq; t.fl = fl; t.ph = ph;
    t.m1 = m1; t.m2 = m2; t.mt = mt; t.s = s; t.cs = cs;
    segs.push_back(t);
  endfunction

  task automatic check(input string name, input logic [16:0] exp);
    logic [16:0] act;
    act = {phase, M1, M2, MT, S, cycle_start};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got {ph,M1,M2,MT,S,cs}=%h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic tk);
    tick = tk;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; side_req = 1'b0; flash_mode = 1'b0;

    // Basic cycle, no requests, tick every clk.
    add(8, 1, 0, 0, P_MAIN, G, G, R, R, 0);
    add(3, 1, 0, 0, P_M2Y,  G, Y, R, R, 0);
    add(6, 1, 0, 0, P_TURN, G, R, G, R, 0);
    add(3, 1, 0, 0, P_TY,   Y, R, Y, R, 0);
    add(1, 1, 0, 0, P_CLRA, R, R, R, R, 0);
    add(8, 1, 0, 0, P_MAIN, G, G, R, R, 1);
    // Single-clk side request during turn green.
    add(3, 1, 0, 0, P_M2Y,  G, Y, R, R, 0);
    add(1, 1, 1, 0, P_TURN, G, R, G, R, 0);
    add(5, 1, 0, 0, P_TURN, G, R, G, R, 0);
    add(3, 1, 0, 0, P_TY,   Y, R, Y, R, 0);
    add(1, 1, 0, 0, P_CLRA, R, R, R, R, 0);
    add(4, 1, 0, 0, P_SG,   R, R, R, G, 0);
    add(3, 1, 0, 0, P_SY,   R, R, R, Y, 0);
    add(1, 1, 0, 0, P_CLRB, R, R, R, R, 0);
    add(8, 1, 0, 0, P_MAIN, G, G, R, R, 1);
    // Latch was consumed: side phase skipped.
    add(3, 1, 0, 0, P_M2Y,  G, Y, R, R, 0);
    add(6, 1, 0, 0, P_TURN, G, R, G, R, 0);
    add(3, 1, 0, 0, P_TY,   Y, R, Y, R, 0);
    add(1, 1, 0, 0, P_CLRA, R, R, R, R, 0);
    // Tick every 4th clk.
    add(32, 4, 0, 0, P_MAIN, G, G, R, R, 1);
    add(12, 4, 0, 0, P_M2Y,  G, Y, R, R, 0);
    add(24, 4, 0, 0, P_TURN, G, R, G, R, 0);
    add(12, 4, 0, 0, P_TY,   Y, R, Y, R, 0);
    add(4,  4, 0, 0, P_CLRA, R, R, R, R, 0);
    // side_req held high: served every cycle.
    add(8, 1, 1, 0, P_MAIN, G, G, R, R, 1);
    add(3, 1, 1, 0, P_M2Y,  G, Y, R, R, 0);
    add(6, 1, 1, 0, P_TURN, G, R, G, R, 0);
    add(3, 1, 1, 0, P_TY,   Y, R, Y, R, 0);
    add(1, 1, 1, 0, P_CLRA, R, R, R, R, 0);
    add(4, 1, 1, 0, P_SG,   R, R, R, G, 0);
    add(3, 1, 1, 0, P_SY,   R, R, R, Y, 0);
    add(1, 1, 1, 0, P_CLRB, R, R, R, R, 0);
    add(8, 1, 1, 0, P_MAIN, G, G, R, R, 1);
    add(3, 1, 1, 0, P_M2Y,  G, Y, R, R, 0);
    add(6, 1, 1, 0, P_TURN, G, R, G, R, 0);
    add(3, 1, 1, 0, P_TY,   Y, R, Y, R, 0);
    add(1, 1, 1, 0, P_CLRA, R, R, R, R, 0);
    // Request drops on the entry edge: clear must win, so next side is skipped.
    add(4, 1, 0, 0, P_SG,   R, R, R, G, 0);
    add(3, 1, 0, 0, P_SY,   R, R, R, Y, 0);
    add(1, 1, 0, 0, P_CLRB, R, R, R, R, 0);
    add(8, 1, 0, 0, P_MAIN, G, G, R, R, 1);
    add(3, 1, 0, 0, P_M2Y,  G, Y, R, R, 0);
    add(6, 1, 0, 0, P_TURN, G, R, G, R, 0);
    add(3, 1, 0, 0, P_TY,   Y, R, Y, R, 0);
    add(1, 1, 0, 0, P_CLRA, R, R, R, R, 0);
    // Flash requested in main green: waits for CLR_A, blinks per tick.
    add(8, 1, 0, 1, P_MAIN, G, G, R, R, 1);
    add(3, 1, 0, 1, P_M2Y,  G, Y, R, R, 0);
    add(6, 1, 0, 1, P_TURN, G, R, G, R, 0);
    add(3, 1, 0, 1, P_TY,   Y, R, Y, R, 0);
    add(1, 1, 0, 1, P_CLRA, R, R, R, R, 0);
    add(1, 1, 0, 1, P_FL,   O, O, O, O, 0);
    add(1, 1, 0, 1, P_FL,   Y, Y, Y, R, 0);
    add(1, 1, 0, 1, P_FL,   O, O, O, O, 0);
    add(1, 1, 0, 1, P_FL,   Y, Y, Y, R, 0);
    add(2, 2, 0, 1, P_FL,   O, O, O, O, 0);
    add(2, 2, 0, 0, P_FL,   Y, Y, Y, R, 0);
    add(1, 1, 0, 0, P_CLRB, R, R, R, R, 0);
    add(8, 1, 0, 0, P_MAIN, G, G, R, R, 1);

    step(1'b0);
    reset = 1'b0;

    foreach (segs[k]) begin
      for (int unsigned i = 0; i < segs[k].n; i++) begin
        check($sformatf("seg%0d_cyc%0d", k, i),
              {segs[k].ph, segs[k].m1, segs[k].m2, segs[k].mt, segs[k].s,
               (i == 0) ? segs[k].cs : 1'b0});
        side_req   = segs[k].sreq;
        flash_mode = segs[k].fl;
        step((segs[k].per != 0) && ((i % segs[k].per) == segs[k].per - 1));
      end
    end

    // Reset in the middle of TURN_YEL with tick low.
    side_req = 1'b0; flash_mode = 1'b0;
    for (int unsigned i = 0; i < 10; i++) step(1'b1);
    check("pre_reset_turn_yel", {P_TY, Y, R, Y, R, 1'b0});
    reset = 1'b1;
    step(1'b0);
    reset = 1'b0;
    check("post_reset_state", {P_MAIN, G, G, R, R, 1'b0});
    for (int unsigned i = 0; i < 7; i++) step(1'b1);
    check("post_reset_main_held", {P_MAIN, G, G, R, R, 1'b0});
    step(1'b1);
    check("post_reset_main_len", {P_M2Y, G, Y, R, R, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
- Parametrised successor to the fixed 4-approach junction controller. Drives the same four signal heads: main-1, main-2, main-turn and side.
- Phase durations are parameters and count a 1-tick strobe rather than raw clocks.
- Adds all-red clearance phases, demand-actuated side phase (skipped if no request) and a night flash mode.
- Sits between the tick prescaler and the lamp driver block.

Parameters:
- CNT_W, 4, width of the phase tick counter.
- T_MAIN, 8, ticks of main green (M1+M2 green).
- T_YEL, 3, ticks of every yellow phase.
- T_TURN, 6, ticks of turn green (M1+MT green).
- T_CLR, 1, ticks of each all-red clearance phase.
- T_SIDE, 4, ticks of side green.
- SIDE_SKIP_EN, 1, 1 = skip side phase when no request latched; 0 = always serve side.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; fully initialises the block on the clk edge where it is sampled high
- tick  in  1  single-cycle timing strobe; all durations count ticks
- side_req  in  1  side-road detector/pedestrian button, level or pulse
- flash_mode  in  1  night mode request
- M1  out  3  main-1 lamp {R,Y,G}
- M2  out  3  main-2 lamp {R,Y,G}
- MT  out  3  main-turn lamp {R,Y,G}
- S  out  3  side lamp {R,Y,G}
- phase  out  4  current FSM state encoding
- cycle_start  out  1  one-clk pulse on entry to MAIN_GREEN

Behaviour:
- Lamp codes: RED=100, YEL=010, GRN=001, OFF=000.
- Reset state: state MAIN_GREEN, count 0, req latch 0, blink 0, cycle_start 0.
- Reset outputs: M1=M2=001, MT=100, S=100.
- Outputs: combinational decode of registered state and blink; no extra latency.
- Counter: increments only on clk edges with tick=1. State with duration T is left on the tick where count==T-1; count then returns to 0, so each phase lasts exactly T ticks.
- Duration of 0 is illegal and is treated as 1 (elaboration assert).
- FSM states, lamps shown in order M1/M2/MT/S:
  - MAIN_GREEN: GRN/GRN/RED/RED -> M2_YEL
  - M2_YEL: GRN/YEL/RED/RED -> TURN_GREEN
  - TURN_GREEN: GRN/RED/GRN/RED -> TURN_YEL
  - TURN_YEL: YEL/RED/YEL/RED -> CLR_A
  - CLR_A, all RED: -> SIDE_GREEN if req=1 or SIDE_SKIP_EN=0, else -> MAIN_GREEN
  - SIDE_GREEN: RED/RED/RED/GRN -> SIDE_YEL
  - SIDE_YEL: RED/RED/RED/YEL -> CLR_B
  - CLR_B, all RED: -> MAIN_GREEN
  - FLASH: M1/M2/MT = YEL when blink else OFF; S = RED when blink else OFF
- Side request latch:
  - Set on any clk with side_req=1.
  - Cleared on entry to SIDE_GREEN.
  - Set and clear in the same cycle: clear wins. A new request during SIDE_GREEN re-latches on later cycles.
- Flash entry: flash_mode is sampled only at the end of CLR_A or CLR_B. If flash_mode=1 there, next state is FLASH (count 0, blink 0). Flash never interrupts a green or yellow phase.
- Flash operation: blink toggles on every tick.
- Flash exit: tick with flash_mode=0 -> CLR_B, which is a full T_CLR, then MAIN_GREEN.
- cycle_start: asserted one cycle on every transition into MAIN_GREEN, including after CLR_B and after a skipped side phase. Not asserted out of reset.
- Reset mid-phase: immediate return to the reset state on the next edge, regardless of tick.
- Illegal state encodings: all lamps RED, next state CLR_B.

Decomposition:
- Shared package tl_pkg holds:
  - lamp constants LAMP_RED/YEL/GRN/OFF
  - the phase_t enum (9 states, 4 bits)
  - a lamp_set_t struct {m1,m2,mt,s}
  - a function decode_lamps(phase, blink)
- Natural sub-module: tl_phase_timer, holding the counter, tick gating, and a done flag for a selected duration.

Test Plan:
- Reset, then tick=1 every clk, side_req=0, SIDE_SKIP_EN=1 -> MAIN 8, M2_YEL 3, TURN 6, TURN_YEL 3, CLR_A 1, then MAIN again; cycle_start pulses every 21 clks.
- Pulse side_req for 1 clk during TURN_GREEN -> after CLR_A: SIDE_GREEN 4 (S=001), SIDE_YEL 3 (S=010), CLR_B 1, then MAIN; req latch is 0 after SIDE_GREEN entry; period 29 clks.
- tick asserted every 4th clk -> MAIN_GREEN holds 32 clks; no state change on non-tick clks.
- Raise flash_mode during MAIN_GREEN -> sequence completes to CLR_A, then FLASH; M1 alternates 010/000 each tick, S alternates 100/000; drop flash_mode -> CLR_B 1 tick, then MAIN with a cycle_start pulse.
- Assert reset for 1 clk mid TURN_YEL -> next cycle M1=M2=001, MT=S=100, phase=MAIN_GREEN, count restarts at 0.
- Hold side_req high throughout -> side served every cycle; latch clears on entry and re-sets the next clk; no skipped side phase.
